// File: rtl/du_pkg.sv
// du_pkg: constants shared by the debug-unit blocks.
//   - Framing/handshake byte values used by the master, the register
//     sender and the memory sender.
//   - One-hot state encoding of the register sender FSM.
package du_pkg;

  localparam logic [7:0] SOT_BYTE = 8'h01;
  localparam logic [7:0] EOT_BYTE = 8'h04;
  localparam logic [7:0] ACK_BYTE = 8'h06;
  localparam logic [7:0] NAK_BYTE = 8'h15;

  typedef enum logic [5:0] {
    ST_IDLE      = 6'b000001,
    ST_SEND_SOT  = 6'b000010,
    ST_LATCH     = 6'b000100,
    ST_SEND_BYTE = 6'b001000,
    ST_SEND_EOT  = 6'b010000,
    ST_DONE      = 6'b100000
  } regs_state_e;

endpackage

// File: rtl/du_regs_sender.sv
// du_regs_sender: dumps the CPU register file to the host through the
// UART TX FIFO as one frame: SOT, every register LSB-first, EOT.
//
// Ports:
//   clk         system clock
//   i_rst_n     asynchronous active-low reset
//   i_start     level request from the master (sampled in IDLE and DONE)
//   i_reg_data  register-file debug read data for o_reg_addr
//   i_tx_full   TX FIFO full; stalls the frame without losing bytes
//   o_reg_addr  register-file debug read address (registered)
//   o_wr        TX FIFO write enable
//   o_wdata     TX FIFO write data (0x00 when not writing)
//   o_tx_start  UART transmit kick, mirrors o_wr
//   o_done      frame complete, held until i_start drops
module du_regs_sender
  import du_pkg::*;
#(
  parameter int NB_REG       = 32,
  parameter int N_REGS       = 32,
  parameter int NB_ADDR      = 5,
  parameter int NB_UART_DATA = 8
) (
  input  logic                    clk,
  input  logic                    i_rst_n,
  input  logic                    i_start,
  input  logic [NB_REG-1:0]       i_reg_data,
  input  logic                    i_tx_full,
  output logic [NB_ADDR-1:0]      o_reg_addr,
  output logic                    o_wr,
  output logic [NB_UART_DATA-1:0] o_wdata,
  output logic                    o_tx_start,
  output logic                    o_done
);

  localparam int NB_BYTES = NB_REG / NB_UART_DATA;
  localparam int NB_BCNT  = (NB_BYTES > 1) ? $clog2(NB_BYTES) : 1;

  localparam logic [NB_BCNT-1:0] LAST_BYTE = NB_BCNT'(NB_BYTES - 1);
  localparam logic [NB_ADDR-1:0] LAST_IDX  = NB_ADDR'(N_REGS - 1);

  regs_state_e         state,    state_nxt;
  logic [NB_ADDR-1:0]  reg_idx,  reg_idx_nxt;
  logic [NB_BCNT-1:0]  byte_cnt, byte_cnt_nxt;
  logic [NB_REG-1:0]   word_reg, word_reg_nxt;

  logic                    wr;
  logic [NB_UART_DATA-1:0] wdata;

  // State registers
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state    <= ST_IDLE;
      reg_idx  <= '0;
      byte_cnt <= '0;
      word_reg <= '0;
    end else begin
      state    <= state_nxt;
      reg_idx  <= reg_idx_nxt;
      byte_cnt <= byte_cnt_nxt;
      word_reg <= word_reg_nxt;
    end
  end

  // Next-state and write decode. Every write state checks !i_tx_full, so a
  // full FIFO simply freezes all registers for that cycle.
  always_comb begin
    state_nxt    = state;
    reg_idx_nxt  = reg_idx;
    byte_cnt_nxt = byte_cnt;
    word_reg_nxt = word_reg;
    wr           = 1'b0;
    wdata        = '0;

    case (state)
      ST_IDLE: begin
        if (i_start) begin
          state_nxt   = ST_SEND_SOT;
          reg_idx_nxt = '0;
        end
      end

      ST_SEND_SOT: begin
        if (!i_tx_full) begin
          wr        = 1'b1;
          wdata     = NB_UART_DATA'(SOT_BYTE);
          state_nxt = ST_LATCH;
        end
      end

      // Address has been stable since the previous edge, so the
      // register-file read has a full cycle to settle.
      ST_LATCH: begin
        word_reg_nxt = i_reg_data;
        byte_cnt_nxt = '0;
        state_nxt    = ST_SEND_BYTE;
      end

      ST_SEND_BYTE: begin
        if (!i_tx_full) begin
          wr           = 1'b1;
          wdata        = word_reg[NB_UART_DATA-1:0];
          word_reg_nxt = word_reg >> NB_UART_DATA;
          byte_cnt_nxt = byte_cnt + 1'b1;
          if (byte_cnt == LAST_BYTE) begin
            if (reg_idx == LAST_IDX) begin
              state_nxt = ST_SEND_EOT;
            end else begin
              reg_idx_nxt = reg_idx + 1'b1;
              state_nxt   = ST_LATCH;
            end
          end
        end
      end

      ST_SEND_EOT: begin
        if (!i_tx_full) begin
          wr        = 1'b1;
          wdata     = NB_UART_DATA'(EOT_BYTE);
          state_nxt = ST_DONE;
        end
      end

      // Stay here while the request is still asserted so the same request
      // level cannot retrigger a second dump.
      ST_DONE: begin
        if (!i_start) begin
          state_nxt = ST_IDLE;
        end
      end

      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  assign o_reg_addr = reg_idx;
  assign o_wr       = wr;
  assign o_tx_start = wr;
  assign o_wdata    = wdata;
  assign o_done     = (state == ST_DONE);

endmodule

// File: tb/tb_du_regs_sender.sv
module tb_du_regs_sender;

  localparam int NB_REG       = 32;
  localparam int N_REGS       = 32;
  localparam int NB_ADDR      = 5;
  localparam int NB_UART_DATA = 8;
  localparam int FRAME_LEN    = 2 + N_REGS * (NB_REG / 8);

  logic                    clk;
  logic                    i_rst_n;
  logic                    i_start;
  logic [NB_REG-1:0]       i_reg_data;
  logic                    i_tx_full;
  logic [NB_ADDR-1:0]      o_reg_addr;
  logic                    o_wr;
  logic [NB_UART_DATA-1:0] o_wdata;
  logic                    o_tx_start;
  logic                    o_done;

  logic [NB_REG-1:0] reg_file [N_REGS];
  logic [7:0]        exp_q [$];

  int checks;
  int failures;
  int cyc;
  int e0;
  int wr_count;
  int first_wr_cyc;

  du_regs_sender #(
    .NB_REG      (NB_REG),
    .N_REGS      (N_REGS),
    .NB_ADDR     (NB_ADDR),
    .NB_UART_DATA(NB_UART_DATA)
  ) dut (
    .clk       (clk),
    .i_rst_n   (i_rst_n),
    .i_start   (i_start),
    .i_reg_data(i_reg_data),
    .i_tx_full (i_tx_full),
    .o_reg_addr(o_reg_addr),
    .o_wr      (o_wr),
    .o_wdata   (o_wdata),
    .o_tx_start(o_tx_start),
    .o_done    (o_done)
  );

  assign i_reg_data = reg_file[o_reg_addr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int unsigned act, input int unsigned exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc - e0);
    end
  endtask

  // Monitor: pops the expected byte stream whenever the DUT writes.
  always @(negedge clk) begin
    if (i_rst_n) begin
      chk("tx_start_eq_wr", o_tx_start, o_wr);
      if (o_wr) begin
        chk("wr_while_full", i_tx_full, 0);
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_write: got 0x%0h expected no write (cycle %0d)", o_wdata, cyc - e0);
        end else begin
          automatic logic [7:0] e = exp_q.pop_front();
          chk("wdata", o_wdata, e);
          if (wr_count == 0) first_wr_cyc = cyc - e0;
          wr_count++;
        end
      end else begin
        chk("idle_wdata_zero", o_wdata, 0);
      end
    end
  end

  task automatic load_regs(input bit fixed);
    for (int k = 0; k < N_REGS; k++)
      reg_file[k] = fixed ? (32'h11223300 + k) : $urandom;
  endtask

  task automatic build_frame();
    exp_q.delete();
    exp_q.push_back(8'h01);
    for (int k = 0; k < N_REGS; k++)
      for (int b = 0; b < NB_REG / 8; b++)
        exp_q.push_back(reg_file[k][8*b +: 8]);
    exp_q.push_back(8'h04);
    wr_count     = 0;
    first_wr_cyc = -1;
  endtask

  // Starts a frame and runs until o_done. Inputs change 1 time unit after
  // the rising edge; cycle index c counts from the edge that samples i_start.
  task automatic run_frame(input int stall_at, input int stall_len, input int drop_at,
                           input int full_pct, input int exp_done, input bit check_first);
    bit done_seen;
    int c;
    build_frame();
    @(posedge clk); #1;
    i_start = 1'b1;
    e0 = cyc;
    done_seen = 1'b0;
    c = 0;
    for (int n = 0; n < 3000 && !done_seen; n++) begin
      @(posedge clk); #1;
      c = cyc - e0;
      if (o_done) begin
        done_seen = 1'b1;
      end else begin
        if (stall_at > 0)
          i_tx_full = (c >= stall_at) && (c < stall_at + stall_len);
        else if (full_pct > 0)
          i_tx_full = ($urandom_range(99) < full_pct);
        if (drop_at > 0 && c == drop_at) i_start = 1'b0;
      end
    end
    i_tx_full = 1'b0;
    if (!done_seen) begin
      checks++;
      failures++;
      $display("FAIL done_timeout: got no o_done expected o_done within 3000 cycles");
    end else begin
      if (exp_done > 0) chk("done_cycle", c, exp_done);
      else chk("done_not_early", (c >= 163), 1);
      chk("bytes_written", wr_count, FRAME_LEN);
      chk("queue_empty_at_done", exp_q.size(), 0);
      if (check_first) chk("first_write_cycle", first_wr_cyc, 1);
    end
  endtask

  task automatic go_idle();
    @(posedge clk); #1;
    i_start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("idle_done_low", o_done, 0);
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_wr"},       o_wr,       0);
    chk({tag, "_tx_start"}, o_tx_start, 0);
    chk({tag, "_wdata"},    o_wdata,    0);
    chk({tag, "_done"},     o_done,     0);
    chk({tag, "_reg_addr"}, o_reg_addr, 0);
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    e0        = 0;
    wr_count  = 0;
    i_rst_n   = 1'b0;
    i_start   = 1'b0;
    i_tx_full = 1'b0;
    load_regs(1'b1);
    repeat (3) @(posedge clk);
    #1;
    chk_outputs_zero("reset");
    i_rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk_outputs_zero("post_reset");

    // Nominal frame, FIFO never full.
    load_regs(1'b1);
    run_frame(0, 0, 0, 0, 163, 1'b1);

    // Request still high in DONE: no restart, no writes.
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      chk("done_hold", o_done, 1);
    end
    i_start = 1'b0;
    @(posedge clk); #1;
    chk("done_clear_next_cycle", o_done, 0);
    repeat (2) @(posedge clk);

    // FIFO full for 3 cycles on register 5 byte 2.
    load_regs(1'b1);
    run_frame(30, 3, 0, 0, 166, 1'b1);
    go_idle();

    // Request drops mid-frame; frame still completes.
    load_regs(1'b0);
    run_frame(0, 0, 20, 0, 163, 1'b1);
    go_idle();

    // Random register contents with random FIFO back-pressure.
    for (int f = 0; f < 3; f++) begin
      load_regs(1'b0);
      run_frame(0, 0, 0, 30, -1, 1'b0);
      go_idle();
    end

    // Asynchronous reset in the middle of register 10.
    load_regs(1'b0);
    build_frame();
    @(posedge clk); #1;
    i_start = 1'b1;
    e0 = cyc;
    while (cyc - e0 < 54) @(posedge clk);
    #3;
    i_rst_n = 1'b0;
    #1;
    chk_outputs_zero("async_reset");
    exp_q.delete();
    i_start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_outputs_zero("in_reset");
    i_rst_n = 1'b1;
    @(posedge clk);
    load_regs(1'b1);
    run_frame(0, 0, 0, 0, 163, 1'b1);
    go_idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
